// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined shifter: operation encodings and the
// illegal-operation predicate used at pipeline entry and inside each stage.
package shifter_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_SLL = 3'd0,
        MODE_SRL = 3'd1,
        MODE_SRA = 3'd2,
        MODE_ROL = 3'd3,
        MODE_ROR = 3'd4
    } mode_e;

    function automatic logic is_illegal_mode(input logic [MODE_W-1:0] mode);
        return mode > MODE_ROR;
    endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Operation/result handshake bundle for the pipelined shifter.
// master drives operations and consumes results; slave is the shifter.
interface pipelined_shifter_if
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    localparam int AMT_W = $clog2(WIDTH);

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [AMT_W-1:0]  in_amt;
    logic [MODE_W-1:0] in_mode;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              out_err;

    modport master (
        output in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );

endinterface

// File: rtl/shift_stage.sv
// One combinational step of the log shifter: moves data by a fixed SHIFT
// positions when enabled; illegal modes pass the data through untouched.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic [WIDTH-1:0]  data,
    input  logic              enable,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  shifted
);

    logic signed [WIDTH-1:0] sdata;

    assign sdata = data;

    always_comb begin
        shifted = data;
        if (enable && !is_illegal_mode(mode)) begin
            case (mode)
                MODE_SLL: shifted = data << SHIFT;
                MODE_SRL: shifted = data >> SHIFT;
                MODE_SRA: shifted = sdata >>> SHIFT;
                MODE_ROL: shifted = {data[WIDTH-1-SHIFT:0], data[WIDTH-1:WIDTH-SHIFT]};
                MODE_ROR: shifted = {data[SHIFT-1:0], data[WIDTH-1:SHIFT]};
                default:  shifted = data;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_shifter.sv
// Log2(WIDTH)-deep barrel shifter/rotator: stage k applies a 2^k move when
// amount bit k is set. All stages advance together under a single stall.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    pipelined_shifter_if.slave bus
);

    localparam int N = $clog2(WIDTH);

    logic [N-1:0]      vld_p;
    logic [WIDTH-1:0]  data_p [N];
    logic [TAG_W-1:0]  tag_p  [N];
    logic [N-1:0]      err_p;
    logic [N-1:0]      amt_p  [N-1];
    logic [MODE_W-1:0] mode_p [N-1];

    logic [WIDTH-1:0]  stage_in   [N];
    logic [MODE_W-1:0] stage_mode [N];
    logic [N-1:0]      stage_en;
    logic [WIDTH-1:0]  shifted    [N];
    logic              advance;

    assign advance = !vld_p[N-1] || bus.out_ready;

    // Amounts are pre-shifted as they travel, so every stage tests bit 0.
    always_comb begin
        stage_in[0]   = bus.in_data;
        stage_mode[0] = bus.in_mode;
        stage_en[0]   = bus.in_amt[0];
        for (int k = 1; k < N; k++) begin
            stage_in[k]   = data_p[k-1];
            stage_mode[k] = mode_p[k-1];
            stage_en[k]   = amt_p[k-1][0];
        end
    end

    for (genvar k = 0; k < N; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .SHIFT (2 ** k)
        ) u_stage (
            .data    (stage_in[k]),
            .enable  (stage_en[k]),
            .mode    (stage_mode[k]),
            .shifted (shifted[k])
        );
    end

    // Stage registers: valid is the only state that needs clearing.
    always_ff @(posedge clock) begin
        if (reset) begin
            vld_p <= '0;
        end else if (advance) begin
            vld_p <= {vld_p[N-2:0], bus.in_valid};
        end
    end

    always_ff @(posedge clock) begin
        if (advance) begin
            data_p[0] <= shifted[0];
            tag_p[0]  <= bus.in_tag;
            err_p[0]  <= is_illegal_mode(bus.in_mode);
            amt_p[0]  <= bus.in_amt >> 1;
            mode_p[0] <= bus.in_mode;
            for (int k = 1; k < N; k++) begin
                data_p[k] <= shifted[k];
                tag_p[k]  <= tag_p[k-1];
                err_p[k]  <= err_p[k-1];
            end
            for (int k = 1; k < N-1; k++) begin
                amt_p[k]  <= amt_p[k-1] >> 1;
                mode_p[k] <= mode_p[k-1];
            end
        end
    end

    // Output gating keeps the result lanes at zero whenever no result is held.
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld_p[N-1];
    assign bus.out_data  = vld_p[N-1] ? data_p[N-1] : '0;
    assign bus.out_tag   = vld_p[N-1] ? tag_p[N-1]  : '0;
    assign bus.out_err   = vld_p[N-1] & err_p[N-1];

endmodule

// File: tb/tb_pipelined_shifter.sv
// Bench for pipelined_shifter: stimulus pushes expected results into a queue,
// an independent monitor pops and compares on every output transfer.
module tb_pipelined_shifter;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;
    localparam int N     = 5;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pipelined_shifter_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    pipelined_shifter #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a,
                                              input logic [2:0] m);
        logic signed [31:0] sd;
        logic [63:0]        dd;
        sd = d;
        case (m)
            3'd0: ref_shift = d << a;
            3'd1: ref_shift = d >> a;
            3'd2: ref_shift = 32'(sd >>> a);
            3'd3: begin dd = {d, d} << a; ref_shift = dd[63:32]; end
            3'd4: begin dd = {d, d} >> a; ref_shift = dd[31:0]; end
            default: ref_shift = d;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    // One cycle of stimulus; records an expected result if the op is accepted.
    task automatic step(input logic v, input logic [31:0] d, input logic [4:0] a,
                        input logic [2:0] m, input logic [3:0] t, input logic ordy,
                        input logic use_exp, input logic [31:0] exp_d, output logic acc);
        exp_t e;
        @(negedge clock);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_amt    = a;
        bus.in_mode   = m;
        bus.in_tag    = t;
        bus.out_ready = ordy;
        #1;
        acc = v && bus.in_ready && !reset;
        if (acc) begin
            e.data = use_exp ? exp_d : ref_shift(d, a, m);
            e.tag  = t;
            e.err  = (m > 3'd4);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, 32'h0, 5'd0, 3'd0, 4'd0, ordy, 1'b0, 32'h0, acc);
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [2:0] m,
                        input logic [3:0] t, input logic use_exp, input logic [31:0] exp_d);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            step(1'b1, d, a, m, t, 1'b1, use_exp, exp_d, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got no acceptance in %0d cycles, required 1", n);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            idle(1'b1);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d results pending, required 0", exp_q.size());
        end
    endtask

    task automatic latency_test(input logic [31:0] d, input logic [4:0] a, input logic [2:0] m,
                                input logic [31:0] exp_d, input string name);
        int lat;
        send(d, a, m, 4'd1, 1'b1, exp_d);
        lat = 0;
        while (lat < 20) begin
            idle(1'b1);
            lat++;
            if (bus.out_valid) break;
        end
        check(name, 32'(lat), 32'(N));
        drain();
    endtask

    // Reset for 'cycles' edges with an operation presented throughout.
    task automatic do_reset(input int cycles);
        @(negedge clock);
        reset         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'hDEADBEEF;
        bus.in_amt    = 5'd3;
        bus.in_mode   = 3'd0;
        bus.in_tag    = 4'hF;
        bus.out_ready = 1'b1;
        exp_q.delete();
        repeat (cycles) @(negedge clock);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check("ready_after_reset", 32'(bus.in_ready), 32'd1);
        check("valid_after_reset", 32'(bus.out_valid), 32'd0);
        check("err_after_reset", 32'(bus.out_err), 32'd0);
        check("data_after_reset", bus.out_data, 32'h0);
        check("tag_after_reset", 32'(bus.out_tag), 32'd0);
    endtask

    exp_t mon_e;
    exp_t prev;
    logic prev_stall = 1'b0;

    always begin
        @(negedge clock);
        #2;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_data", bus.out_data, prev.data);
                check("stall_tag", 32'(bus.out_tag), 32'(prev.tag));
                check("stall_err", 32'(bus.out_err), 32'(prev.err));
            end
            if (!bus.out_valid) begin
                check("idle_err", 32'(bus.out_err), 32'd0);
            end else if (bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got tag %0d data 0x%08h, required no output",
                             bus.out_tag, bus.out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", bus.out_data, mon_e.data);
                    check("out_tag", 32'(bus.out_tag), 32'(mon_e.tag));
                    check("out_err", 32'(bus.out_err), 32'(mon_e.err));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev.data  = bus.out_data;
            prev.tag   = bus.out_tag;
            prev.err   = bus.out_err;
        end
    end

    initial begin
        logic       acc;
        logic       ordy;
        int         rel;
        int         sent;
        int         iter;
        logic [2:0] m;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        do_reset(3);

        latency_test(32'h80000000, 5'd4, 3'd2, 32'hF8000000, "latency_sra");
        latency_test(32'h80000000, 5'd4, 3'd1, 32'h08000000, "latency_srl");

        send(32'h00000001, 5'd1,  3'd4, 4'd2, 1'b1, 32'h80000000);
        send(32'h80000001, 5'd31, 3'd3, 4'd3, 1'b1, 32'hC0000000);
        send(32'h00000001, 5'd31, 3'd0, 4'd4, 1'b1, 32'h80000000);
        send(32'hA5A5A5A5, 5'd0,  3'd2, 4'd5, 1'b1, 32'hA5A5A5A5);
        drain();

        rel  = 0;
        sent = 0;
        while ((sent < 8 || rel < 14) && rel < 200) begin
            ordy = !(rel >= 7 && rel <= 9);
            if (sent < 8)
                step(1'b1, $urandom, 5'($urandom), 3'($urandom_range(0, 4)), 4'(sent),
                     ordy, 1'b0, 32'h0, acc);
            else
                step(1'b0, 32'h0, 5'd0, 3'd0, 4'd0, ordy, 1'b0, 32'h0, acc);
            if (acc) sent++;
            rel++;
        end
        check("stall_sent", 32'(sent), 32'd8);
        drain();

        send(32'h12345678, 5'd3, 3'd6, 4'd9,  1'b1, 32'h12345678);
        send(32'h12345678, 5'd4, 3'd0, 4'd10, 1'b1, 32'h23456780);
        drain();

        send(32'h0000FFFF, 5'd2, 3'd0, 4'd11, 1'b0, 32'h0);
        send(32'hF0000000, 5'd3, 3'd2, 4'd12, 1'b0, 32'h0);
        send(32'h00000003, 5'd5, 3'd3, 4'd13, 1'b0, 32'h0);
        do_reset(2);
        for (int i = 0; i < 10; i++) begin
            idle(1'b1);
            check("flush_silent", 32'(bus.out_valid), 32'd0);
        end

        sent = 0;
        iter = 0;
        while (sent < 10000 && iter < 60000) begin
            m = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            step($urandom_range(0, 9) < 7, $urandom, 5'($urandom), m, 4'($urandom),
                 $urandom_range(0, 9) < 7, 1'b0, 32'h0, acc);
            if (acc) sent++;
            iter++;
        end
        check("random_sent", 32'(sent), 32'd10000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 Parameter WIDTH, default 32: operand width; SHALL be a power of two, at least 4.
REQ-002 Parameter TAG_W, default 4: width of the sideband tag carried with each operation.
REQ-003 Derived constant N = log2(WIDTH) SHALL set both the amount width and the pipeline depth.
REQ-004 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  upstream presents an operation.
REQ-007 in_ready  out  1  block accepts the operation this cycle.
REQ-008 in_data  in  WIDTH  operand.
REQ-009 in_amt  in  N  shift amount, 0..WIDTH-1.
REQ-010 in_mode  in  3  operation: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR; 5-7 illegal.
REQ-011 in_tag  in  TAG_W  opaque tag, returned unchanged.
REQ-012 out_valid  out  1  result available.
REQ-013 out_ready  in  1  downstream accepts the result.
REQ-014 out_data  out  WIDTH  result.
REQ-015 out_tag  out  TAG_W  tag of the operation in out_data.
REQ-016 out_err  out  1  operation had an illegal mode.

Function
REQ-017 Transfer SHALL occur on an interface exactly when valid and ready are both high on a rising edge.
REQ-018 The pipeline SHALL have N register stages; stage k applies a shift of 2^k when amount bit k is set, and passes data unchanged otherwise.
REQ-019 Each stage SHALL carry valid, data, the remaining amount bits, mode, tag and err.
REQ-020 Global advance SHALL be defined as advance = !out_valid || out_ready; all stages shift forward together when advance is high and hold otherwise.
REQ-021 in_ready SHALL equal advance, combinationally; in_ready does not depend on in_valid.
REQ-022 Latency SHALL be exactly N cycles from acceptance to out_valid when out_ready is held high; throughput SHALL be one operation per cycle.
REQ-023 Bubbles SHALL NOT be collapsed; an empty stage advances as an invalid slot.
REQ-024 SLL and SRL SHALL fill vacated bits with 0; SRA SHALL fill with operand bit WIDTH-1.
REQ-025 ROL and ROR SHALL rotate with no bit loss; an amount of 0 SHALL return the operand for every mode.
REQ-026 Illegal mode: out_data SHALL equal in_data, out_err=1, and the operation still occupies one pipeline slot.
REQ-027 out_data, out_tag and out_err SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 When out_valid=0, out_err SHALL be 0; out_data and out_tag SHALL be ignored by consumers.

Reset
REQ-029 While reset is high, every stage valid bit SHALL clear and out_valid, out_err, out_data and out_tag SHALL read 0 on the following edge.
REQ-030 Reset mid-operation SHALL discard all in-flight operations with no output.
REQ-031 An input presented in the reset cycle SHALL NOT be accepted.
REQ-032 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-033 Package shifter_pkg SHALL hold the mode encodings and an illegal-mode predicate.
REQ-034 One sub-module, shift_stage, SHALL be instantiated N times with a fixed parameter SHIFT = 2^k.
REQ-035 shift_stage SHALL be combinational with inputs data, enable and mode, and the output shifted data.
REQ-036 The stage registers SHALL live in pipelined_shifter.

Verification (WIDTH=32, N=5, out_ready=1 unless stated)
REQ-037 SRA: 0x80000000, amt 4 -> 0xF8000000; SRL same operand -> 0x08000000; both 5 cycles after acceptance.
REQ-038 ROR: 0x00000001, amt 1 -> 0x80000000; ROL: 0x80000001, amt 31 -> 0xC0000000; SLL: 0x00000001, amt 31 -> 0x80000000.
REQ-039 Back-to-back tags 0..7 with out_ready low for cycles 7-9 -> no loss, no duplication, in-order tags, out_data held stable while stalled.
REQ-040 Mode 6, operand 0x12345678 -> out_data 0x12345678, out_err=1; the next legal operation -> out_err=0.
REQ-041 Reset asserted with 3 operations in flight -> out_valid stays 0, nothing emitted, in_ready=1 after release.
REQ-042 Random test of 10k operations against a reference model across all modes and amounts, with random in_valid and out_ready -> zero mismatches.
